// File: rtl/debug_access_gate.sv
// rtl/debug_access_gate.sv - authenticating gate in front of the debug register file
// Only config/status are ever forwarded; key words and unknown addresses are denied.
module debug_access_gate #(
  parameter logic [31:0] AUTH_KEY       = 32'hA5C3_0F1E,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 1024,
  parameter int unsigned IDLE_CYCLES    = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        unlock_req,
  input  logic [31:0] unlock_key,
  input  logic        relock,
  input  logic        dbg_req,
  input  logic [7:0]  dbg_addr,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata,
  output logic        dbg_err,
  output logic        rf_rd_en,
  output logic [7:0]  rf_addr,
  input  logic [31:0] rf_rdata,
  output logic        locked,
  output logic        lockout,
  output logic [3:0]  fail_count
);

  localparam int LW = (LOCKOUT_CYCLES > 2) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam int IW = (IDLE_CYCLES > 2) ? $clog2(IDLE_CYCLES) : 1;
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
  localparam logic [4:0]    FAIL_LIMIT = 5'(MAX_FAILS);

  typedef enum logic [1:0] {
    S_LOCKED   = 2'd0,
    S_UNLOCKED = 2'd1,
    S_RF_WAIT  = 2'd2,
    S_LOCKOUT  = 2'd3
  } state_t;

  state_t          state;
  logic [LW-1:0]   lock_timer;
  logic [IW-1:0]   idle_cnt;

  // A request still high during its own ack cycle is not accepted again,
  // which keeps dbg_ack from ever being high two cycles in a row.
  logic req_new;
  logic key_ok;
  logic rf_hit;
  logic fail_hits_limit;

  assign req_new         = dbg_req && !dbg_ack;
  assign key_ok          = (unlock_key == AUTH_KEY);
  assign rf_hit          = (dbg_addr == 8'h10) || (dbg_addr == 8'h11);
  assign fail_hits_limit = (({1'b0, fail_count} + 5'd1) == FAIL_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_LOCKED;
      lock_timer <= '0;
      idle_cnt   <= '0;
      dbg_ack    <= 1'b0;
      dbg_rdata  <= '0;
      dbg_err    <= 1'b0;
      rf_rd_en   <= 1'b0;
      rf_addr    <= '0;
      locked     <= 1'b1;
      lockout    <= 1'b0;
      fail_count <= '0;
    end else begin
      dbg_ack   <= 1'b0;
      dbg_err   <= 1'b0;
      dbg_rdata <= '0;
      rf_rd_en  <= 1'b0;

      case (state)
        S_LOCKED: begin
          if (unlock_req) begin
            if (key_ok) begin
              state      <= S_UNLOCKED;
              locked     <= 1'b0;
              fail_count <= '0;
              idle_cnt   <= '0;
            end else begin
              if (fail_count != 4'hF) begin
                fail_count <= fail_count + 4'd1;
              end
              if (fail_hits_limit) begin
                state      <= S_LOCKOUT;
                lockout    <= 1'b1;
                lock_timer <= '0;
              end
            end
          end
          // Even when this same cycle unlocks, the request is denied.
          if (req_new) begin
            dbg_ack <= 1'b1;
            dbg_err <= 1'b1;
          end
        end

        S_LOCKOUT: begin
          if (req_new) begin
            dbg_ack <= 1'b1;
            dbg_err <= 1'b1;
          end
          if (lock_timer == LOCK_LAST) begin
            state      <= S_LOCKED;
            lockout    <= 1'b0;
            fail_count <= '0;
            lock_timer <= '0;
          end else begin
            lock_timer <= lock_timer + 1'b1;
          end
        end

        S_UNLOCKED: begin
          if (relock) begin
            state  <= S_LOCKED;
            locked <= 1'b1;
            if (req_new) begin
              dbg_ack <= 1'b1;
              dbg_err <= 1'b1;
            end
          end else if (req_new) begin
            idle_cnt <= '0;
            if (rf_hit) begin
              rf_rd_en <= 1'b1;
              rf_addr  <= dbg_addr;
              state    <= S_RF_WAIT;
            end else begin
              dbg_ack <= 1'b1;
              dbg_err <= 1'b1;
            end
          end else if (dbg_req) begin
            idle_cnt <= '0;
          end else if (idle_cnt == IDLE_LAST) begin
            state    <= S_LOCKED;
            locked   <= 1'b1;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end

        S_RF_WAIT: begin
          dbg_ack   <= 1'b1;
          dbg_rdata <= rf_rdata;
          idle_cnt  <= '0;
          // A relock here still lets the in-flight read finish.
          if (relock) begin
            state  <= S_LOCKED;
            locked <= 1'b1;
          end else begin
            state <= S_UNLOCKED;
          end
        end

        default: begin
          state  <= S_LOCKED;
          locked <= 1'b1;
        end
      endcase
    end
  end

endmodule
